uart_rx_ovs: RTL and testbench
==============================

// Module: uart_rx_ovs
// PURPOSE
//  Parametrised oversampling UART receiver; next-generation replacement for the fixed 8-bit receiver.
//  Recovers one serial frame per start bit from rxd, clocked by bclk at OVS x baud.
//  Supports configurable data width, parity and stop bits; flags framing, parity and overrun errors.
//  Sits between the pad-side rxd line and the loopback/transmit path; word handed over by valid/ack.
// PARAMETERS
//  DATA_BITS  8   data bits per frame, legal 5..9, LSB first
//  OVS        16  bclk cycles per bit, even, >= 8
//  PARITY     0   0 = none, 1 = odd, 2 = even
//  STOP_BITS  1   1 or 2; each stop bit is checked
// PORTS
//  bclk        in   1          oversample clock, OVS x baud
//  rst         in   1          async reset, active-high
//  rxd         in   1          serial input, idle high, asynchronous to bclk
//  rx_dout     out  DATA_BITS  received word, valid while rx_valid=1
//  rx_valid    out  1          word available; held until accepted
//  rx_ack      in   1          consumer accepts word when rx_valid & rx_ack
//  frame_err   out  1          a stop bit of the current word sampled low; qualified by rx_valid
//  parity_err  out  1          parity mismatch in the current word (0 when PARITY=0); qualified by rx_valid
//  overrun     out  1          sticky: a completed frame was dropped
//  ovr_clr     in   1          single-cycle clear of overrun
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; 2-flop synchroniser preset to 1; counters cleared. Reset mid-frame aborts the frame.
//  rxd passes a 2-flop synchroniser (rxd_s); all timing below is relative to rxd_s.
//  FSM IDLE -> START -> DATA -> [PAR] -> STOP -> IDLE; tick counter 0..OVS-1; bit counter 0..N-1.
//   IDLE: armed only after rxd_s seen high; rxd_s=0 at cycle t0 -> START.
//   START: sample at t0+OVS/2; if rxd_s=1 it is a false start -> IDLE, no output.
//   DATA: data bit k sampled at t0+OVS/2+(k+1)*OVS, shifted in LSB first.
//   PAR (PARITY!=0): sampled one bit-time after the last data bit; odd/even check over data+parity.
//   STOP: stop bit j sampled one bit-time after the preceding bit; any stop sample = 0 -> frame_err.
//   After the final stop sample: IDLE the next cycle; back-to-back frames with no idle gap are supported.
//  Delivery: rx_valid rises 1 bclk after the final stop sample; rx_dout and error flags load in the same cycle.
//   rx_dout and the error flags are stable while rx_valid=1; rx_valid falls the cycle after rx_valid & rx_ack.
//  Boundaries:
//   - Completion while rx_valid=1 with no ack: new word dropped, old word kept, overrun <= 1.
//   - Completion in the same cycle as an ack: new word loaded, rx_valid stays 1, no overrun.
//   - ovr_clr together with a new overrun event: overrun stays set (set wins).
//   - Break (rxd held low): completes with data 0 and frame_err=1; no re-arm until rxd_s returns high.
//   - rx_ack while rx_valid=0: ignored.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each bit is taken as the 2-of-3 majority of rxd_s at mid-1, mid and mid+1.
//   The decision, and therefore all downstream timing including rx_valid, occurs 1 bclk later.
//   The false-start check uses the majority value.
//  Not defined: each bit is taken from a single sample at mid; timing exactly as in BEHAVIOUR.
// TESTING  (bclk 20 ns, OVS=16, bit = 320 ns, defaults unless stated)
//  1. 8N1 frame 0xA5, idle high between frames -> rx_valid=1, rx_dout=0xA5, frame_err=0, parity_err=0;
//     rx_valid rises t0+OVS/2+9*OVS+1 cycles after the start edge; rx_ack for 1 cycle -> rx_valid=0.
//  2. rxd low for 4 bclk, then high -> no rx_valid; FSM in IDLE; frame 0x3C sent next is received.
//  3. Frame 0x3C with the stop bit driven 0 -> rx_dout=0x3C, frame_err=1; rxd then held low: no new frame
//     until rxd goes high; next frame 0x81 is received with frame_err=0.
//  4. PARITY=2, data 0x07, parity bit 0 -> parity_err=1; repeat with parity bit 1 -> parity_err=0.
//  5. Frames 0x11 then 0x22 back-to-back, no ack -> rx_dout=0x11, overrun=1; ack+ovr_clr -> both 0.
//  6. rst pulse during data bit 3 -> all outputs 0 within the reset; next frame 0x5A received with no errors.
//  Run all six with UART_RX_MAJORITY_EN defined and undefined; add DATA_BITS=9, STOP_BITS=2 with frame 0x1FF.

Source files
------------

// File: rtl/uart_rx_ovs.sv
`timescale 1ns/1ps
// uart_rx_ovs
//   Oversampling UART receiver. Recovers one frame per start bit from rxd
//   using bclk running at OVS x baud. Data width, parity mode and number of
//   stop bits are parameters. Flags framing, parity and overrun errors and
//   hands the received word over with a valid/ack handshake.
//
// Parameters
//   DATA_BITS  data bits per frame (5..9), LSB first
//   OVS        bclk cycles per bit (even, >= 8)
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2, every stop bit is checked
//
// Ports
//   bclk        in   oversample clock
//   rst         in   asynchronous reset, active high
//   rxd         in   serial input, idle high, asynchronous to bclk
//   rx_dout     out  received word, meaningful while rx_valid = 1
//   rx_valid    out  word available, held until accepted
//   rx_ack      in   word accepted when rx_valid & rx_ack
//   frame_err   out  a stop bit of the current word sampled low
//   parity_err  out  parity mismatch in the current word
//   overrun     out  sticky, a completed frame was dropped
//   ovr_clr     in   clears overrun (a simultaneous new overrun wins)
//
// Build option
//   UART_RX_MAJORITY_EN : each bit is the 2-of-3 majority of rxd_s at
//   mid-1, mid and mid+1; every decision (and rx_valid) lands one bclk later.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a falling edge on rxd_s (armed once rxd_s seen high)
// S_START | timing to the middle of the start bit, rejects false starts
// S_DATA  | sampling DATA_BITS data bits, LSB first
// S_PAR   | sampling the parity bit (only when PARITY != 0)
// S_STOP  | sampling STOP_BITS stop bits, then delivering the word

module uart_rx_ovs #(
  parameter int DATA_BITS = 8,
  parameter int OVS       = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 bclk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 ovr_clr
);

  localparam int CW = $clog2(OVS);
  localparam int BW = 4;
  localparam logic [CW-1:0] BIT_RELOAD = CW'(OVS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state;
  logic                 rxd_m;
  logic                 rxd_s;
  logic                 bit_val;
  logic                 armed;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 par_bad;
  logic                 ferr_acc;
  logic                 frame_done;
  logic                 ovr_set;

  // Two-flop synchroniser, preset to the idle level.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // The decision is taken at mid+1 so that rxd_s, rxd_d1 and rxd_d2 hold
  // the samples from mid+1, mid and mid-1 respectively.
  localparam logic [CW-1:0] FIRST_WAIT = CW'(OVS / 2);
  logic rxd_d1;
  logic rxd_d2;

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      rxd_d1 <= 1'b1;
      rxd_d2 <= 1'b1;
    end else begin
      rxd_d1 <= rxd_s;
      rxd_d2 <= rxd_d1;
    end
  end

  assign bit_val = (rxd_s & rxd_d1) | (rxd_s & rxd_d2) | (rxd_d1 & rxd_d2);
`else
  // Counter is loaded on the cycle the start edge is seen, so OVS/2-1 more
  // cycles land exactly on the middle of the start bit.
  localparam logic [CW-1:0] FIRST_WAIT = CW'(OVS / 2 - 1);
  assign bit_val = rxd_s;
`endif

  assign frame_done = (state == S_STOP) && (cnt == '0) && (bcnt == '0);
  assign ovr_set    = frame_done && rx_valid && !rx_ack;

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      cnt        <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      ferr_acc   <= 1'b0;
      rx_dout    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Handover. A completion while the old word is still unaccepted is
      // dropped; a completion coinciding with the ack replaces the word.
      if (frame_done) begin
        if (!ovr_set) begin
          rx_valid   <= 1'b1;
          rx_dout    <= shreg;
          frame_err  <= ferr_acc | ~bit_val;
          parity_err <= par_bad;
        end
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end

      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (rxd_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= S_START;
            armed <= 1'b0;
            cnt   <= FIRST_WAIT;
          end
        end

        S_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (bit_val) begin
            state <= S_IDLE;
            armed <= 1'b1;
          end else begin
            state    <= S_DATA;
            cnt      <= BIT_RELOAD;
            bcnt     <= BW'(DATA_BITS - 1);
            par_acc  <= 1'b0;
            par_bad  <= 1'b0;
            ferr_acc <= 1'b0;
          end
        end

        S_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ bit_val;
            cnt     <= BIT_RELOAD;
            if (bcnt == '0) begin
              state <= (PARITY != 0) ? S_PAR : S_STOP;
              bcnt  <= BW'(STOP_BITS - 1);
            end else begin
              bcnt <= bcnt - 1'b1;
            end
          end
        end

        S_PAR: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // XOR over data+parity must be 1 for odd parity, 0 for even.
            par_bad <= (PARITY == 1) ? ~(par_acc ^ bit_val) : (par_acc ^ bit_val);
            cnt     <= BIT_RELOAD;
            state   <= S_STOP;
          end
        end

        S_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            ferr_acc <= ferr_acc | ~bit_val;
            cnt      <= BIT_RELOAD;
            if (bcnt == '0) begin
              // A low final stop (break) leaves the receiver disarmed until
              // the line has been seen high again.
              state <= S_IDLE;
              armed <= bit_val;
            end else begin
              bcnt <= bcnt - 1'b1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
`timescale 1ns/1ps
module tb_uart_rx_ovs;

  localparam int OVS = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       bclk = 1'b0;
  logic       rst  = 1'b1;
  logic [2:0] rxd_v = 3'b111;
  logic [2:0] ack_v = 3'b000;
  logic [2:0] clr_v = 3'b000;

  logic [7:0] dout0;
  logic [7:0] dout1;
  logic [8:0] dout2;
  logic [2:0] valid_a, ferr_a, perr_a, ovr_a;
  logic [8:0] a_dout [3];

  assign a_dout[0] = {1'b0, dout0};
  assign a_dout[1] = {1'b0, dout1};
  assign a_dout[2] = dout2;

  // u0: 8N1, u1: 8E1, u2: 9N2
  uart_rx_ovs #(.DATA_BITS(8), .OVS(OVS), .PARITY(0), .STOP_BITS(1)) u0 (
    .bclk(bclk), .rst(rst), .rxd(rxd_v[0]), .rx_dout(dout0), .rx_valid(valid_a[0]),
    .rx_ack(ack_v[0]), .frame_err(ferr_a[0]), .parity_err(perr_a[0]),
    .overrun(ovr_a[0]), .ovr_clr(clr_v[0]));

  uart_rx_ovs #(.DATA_BITS(8), .OVS(OVS), .PARITY(2), .STOP_BITS(1)) u1 (
    .bclk(bclk), .rst(rst), .rxd(rxd_v[1]), .rx_dout(dout1), .rx_valid(valid_a[1]),
    .rx_ack(ack_v[1]), .frame_err(ferr_a[1]), .parity_err(perr_a[1]),
    .overrun(ovr_a[1]), .ovr_clr(clr_v[1]));

  uart_rx_ovs #(.DATA_BITS(9), .OVS(OVS), .PARITY(0), .STOP_BITS(2)) u2 (
    .bclk(bclk), .rst(rst), .rxd(rxd_v[2]), .rx_dout(dout2), .rx_valid(valid_a[2]),
    .rx_ack(ack_v[2]), .frame_err(ferr_a[2]), .parity_err(perr_a[2]),
    .overrun(ovr_a[2]), .ovr_clr(clr_v[2]));

  always #10 bclk = ~bclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rise_cyc [3] = '{0, 0, 0};

  function automatic int dw(input int d);
    return (d == 2) ? 9 : 8;
  endfunction
  function automatic int pm(input int d);
    return (d == 1) ? 2 : 0;
  endfunction
  function automatic int sb(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  // Expected deliveries: which receiver, on which bclk edge, with what content.
  typedef struct {
    int         d;
    int         c;
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } ev_t;
  ev_t evq[$];

  logic [2:0] m_valid = '0, m_ferr = '0, m_perr = '0, m_ovr = '0;
  logic [8:0] m_dout [3] = '{9'd0, 9'd0, 9'd0};
  logic [8:0] c_data [3];
  logic [2:0] c_fe, c_pe, done;
  logic       m_set;
  logic [2:0] prev_valid = '0;

  // Handshake model: applies the delivery/ack/overrun rules on each edge.
  always @(posedge bclk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_valid = '0; m_ferr = '0; m_perr = '0; m_ovr = '0;
      for (int d = 0; d < 3; d++) m_dout[d] = '0;
      evq.delete();
    end else begin
      done = '0;
      while (evq.size() > 0 && evq[0].c <= cyc) begin
        if (evq[0].c == cyc) begin
          done[evq[0].d]   = 1'b1;
          c_data[evq[0].d] = evq[0].data;
          c_fe[evq[0].d]   = evq[0].fe;
          c_pe[evq[0].d]   = evq[0].pe;
        end
        void'(evq.pop_front());
      end
      for (int d = 0; d < 3; d++) begin
        m_set = done[d] && m_valid[d] && !ack_v[d];
        if (done[d] && !m_set) begin
          m_valid[d] = 1'b1;
          m_dout[d]  = c_data[d];
          m_ferr[d]  = c_fe[d];
          m_perr[d]  = c_pe[d];
        end else if (!done[d] && m_valid[d] && ack_v[d]) begin
          m_valid[d] = 1'b0;
        end
        if (m_set) m_ovr[d] = 1'b1;
        else if (clr_v[d]) m_ovr[d] = 1'b0;
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge bclk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (valid_a[d] && !prev_valid[d]) rise_cyc[d] = cyc;
        checks++;
        if (valid_a[d] !== m_valid[d]) begin
          errors++;
          $display("FAIL rx_valid[%0d] cyc %0d: got %b expected %b", d, cyc, valid_a[d], m_valid[d]);
        end
        checks++;
        if (ovr_a[d] !== m_ovr[d]) begin
          errors++;
          $display("FAIL overrun[%0d] cyc %0d: got %b expected %b", d, cyc, ovr_a[d], m_ovr[d]);
        end
        if (m_valid[d]) begin
          checks++;
          if (a_dout[d] !== m_dout[d] || ferr_a[d] !== m_ferr[d] || perr_a[d] !== m_perr[d]) begin
            errors++;
            $display("FAIL word[%0d] cyc %0d: got dout %0h fe %b pe %b expected dout %0h fe %b pe %b",
                     d, cyc, a_dout[d], ferr_a[d], perr_a[d], m_dout[d], m_ferr[d], m_perr[d]);
          end
        end
      end
    end
    prev_valid = valid_a;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge bclk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // pmode: 0 correct parity, 1 force parity bit 0, 2 force parity bit 1
  task automatic send_frame(input int d, input logic [8:0] data, input int pmode,
                            input logic stop_v, input logic idle_after, output int p0);
    logic [15:0] fb;
    logic [8:0]  dm;
    logic        pbit;
    int          nb;
    ev_t         e;
    dm = 9'(int'(data) & ((1 << dw(d)) - 1));
    pbit = (pm(d) == 1) ? ~(^dm) : (^dm);
    if (pmode == 1) pbit = 1'b0;
    if (pmode == 2) pbit = 1'b1;
    fb = '0;
    nb = 1;
    for (int i = 0; i < dw(d); i++) begin
      fb[nb] = dm[i];
      nb++;
    end
    if (pm(d) != 0) begin
      fb[nb] = pbit;
      nb++;
    end
    for (int i = 0; i < sb(d); i++) begin
      fb[nb] = stop_v;
      nb++;
    end
    // 2 synchroniser cycles + detection edge, then mid-bit, then nb-1 bit times.
    e.d    = d;
    e.c    = cyc + 3 + OVS / 2 + (nb - 1) * OVS + MAJ;
    e.data = dm;
    e.fe   = ~stop_v;
    e.pe   = (pm(d) == 0) ? 1'b0 :
             (pm(d) == 1) ? ~((^dm) ^ pbit) : ((^dm) ^ pbit);
    evq.push_back(e);
    p0 = cyc;
    for (int i = 0; i < nb; i++) begin
      rxd_v[d] = fb[i];
      tick(OVS);
    end
    rxd_v[d] = idle_after;
  endtask

  task automatic ack(input int d);
    ack_v[d] = 1'b1;
    tick(1);
    ack_v[d] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic [7:0] v5a;
    v5a = 8'h5A;
    tick(3);
    chk("rst_valid", {29'd0, valid_a}, 32'd0);
    chk("rst_dout0", {24'd0, dout0}, 32'd0);
    chk("rst_ovr", {29'd0, ovr_a}, 32'd0);
    rst = 1'b0;
    tick(4);

    // 1: 8N1 0xA5
    send_frame(0, 9'h0A5, 0, 1'b1, 1'b1, p);
    chk("t1_latency", rise_cyc[0] - p, 155 + MAJ);
    chk("t1_dout", {24'd0, dout0}, 32'hA5);
    chk("t1_flags", {30'd0, ferr_a[0], perr_a[0]}, 32'd0);
    ack(0);
    chk("t1_acked", {31'd0, valid_a[0]}, 32'd0);

    // 2: short glitch is a false start
    rxd_v[0] = 1'b0;
    tick(4);
    rxd_v[0] = 1'b1;
    tick(3 * OVS);
    chk("t2_nofalse", {31'd0, valid_a[0]}, 32'd0);
    send_frame(0, 9'h03C, 0, 1'b1, 1'b1, p);
    chk("t2_dout", {24'd0, dout0}, 32'h3C);
    ack(0);

    // 3: stop bit low, line held low, then recovery
    send_frame(0, 9'h03C, 0, 1'b0, 1'b0, p);
    chk("t3_dout", {24'd0, dout0}, 32'h3C);
    chk("t3_ferr", {31'd0, ferr_a[0]}, 32'd1);
    ack(0);
    tick(25 * OVS);
    chk("t3_held_low", {31'd0, valid_a[0]}, 32'd0);
    rxd_v[0] = 1'b1;
    tick(2 * OVS);
    send_frame(0, 9'h081, 0, 1'b1, 1'b1, p);
    chk("t3_dout81", {24'd0, dout0}, 32'h81);
    chk("t3_ferr81", {31'd0, ferr_a[0]}, 32'd0);
    ack(0);

    // break: all-zero frame
    send_frame(0, 9'h000, 0, 1'b0, 1'b0, p);
    chk("brk_ferr", {31'd0, ferr_a[0]}, 32'd1);
    ack(0);
    tick(30 * OVS);
    rxd_v[0] = 1'b1;
    tick(2 * OVS);

    // 4: even parity
    send_frame(1, 9'h007, 1, 1'b1, 1'b1, p);
    chk("t4_perr1", {31'd0, perr_a[1]}, 32'd1);
    chk("t4_dout", {24'd0, dout1}, 32'h07);
    ack(1);
    send_frame(1, 9'h007, 2, 1'b1, 1'b1, p);
    chk("t4_perr0", {31'd0, perr_a[1]}, 32'd0);
    ack(1);
    send_frame(1, 9'h05B, 0, 1'b1, 1'b1, p);
    ack(1);

    // 5: back-to-back, no ack; ovr_clr collides with the overrun event
    send_frame(0, 9'h011, 0, 1'b1, 1'b1, p);
    fork
      send_frame(0, 9'h022, 0, 1'b1, 1'b1, p);
      begin
        tick(155 + MAJ - 1);
        clr_v[0] = 1'b1;
        tick(1);
        clr_v[0] = 1'b0;
      end
    join
    chk("t5_dout", {24'd0, dout0}, 32'h11);
    chk("t5_ovr", {31'd0, ovr_a[0]}, 32'd1);
    ack_v[0] = 1'b1;
    clr_v[0] = 1'b1;
    tick(1);
    ack_v[0] = 1'b0;
    clr_v[0] = 1'b0;
    chk("t5_clr", {30'd0, valid_a[0], ovr_a[0]}, 32'd0);

    // completion in the same cycle as the ack
    send_frame(0, 9'h033, 0, 1'b1, 1'b1, p);
    fork
      send_frame(0, 9'h044, 0, 1'b1, 1'b1, p);
      begin
        tick(155 + MAJ - 1);
        ack_v[0] = 1'b1;
        tick(1);
        ack_v[0] = 1'b0;
      end
    join
    chk("t5_same_dout", {24'd0, dout0}, 32'h44);
    chk("t5_same_ovr", {31'd0, ovr_a[0]}, 32'd0);
    ack(0);
    ack(0);

    // 6: reset during data bit 3, with a word pending
    send_frame(0, 9'h066, 0, 1'b1, 1'b1, p);
    rxd_v[0] = 1'b0;
    tick(OVS);
    for (int i = 0; i < 3; i++) begin
      rxd_v[0] = v5a[i];
      tick(OVS);
    end
    rxd_v[0] = v5a[3];
    tick(OVS / 2);
    rst = 1'b1;
    tick(2);
    chk("t6_rst_out", {24'd0, dout0}, 32'd0);
    chk("t6_rst_flags", {28'd0, valid_a[0], ferr_a[0], perr_a[0], ovr_a[0]}, 32'd0);
    rst = 1'b0;
    rxd_v[0] = 1'b1;
    tick(12 * OVS);
    chk("t6_abort", {31'd0, valid_a[0]}, 32'd0);
    send_frame(0, 9'h05A, 0, 1'b1, 1'b1, p);
    chk("t6_dout", {24'd0, dout0}, 32'h5A);
    chk("t6_flags", {30'd0, ferr_a[0], perr_a[0]}, 32'd0);
    ack(0);

    // 7: 9N2 frame 0x1FF
    send_frame(2, 9'h1FF, 0, 1'b1, 1'b1, p);
    chk("t7_latency", rise_cyc[2] - p, 187 + MAJ);
    chk("t7_dout", {23'd0, dout2}, 32'h1FF);
    chk("t7_ferr", {31'd0, ferr_a[2]}, 32'd0);
    ack(2);

    // ack while nothing is pending
    ack(0);
    chk("idle_ack", {31'd0, valid_a[0]}, 32'd0);
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
